filtro_fir_seq: RTL
===================

Name: filtro_fir_seq

Overview:
- Parametrised successor to the fixed 20-bit filter top: a signed fixed-point FIR filter with a run-time loadable coefficient bank.
- Uses a single shared multiplier (sequential MAC) and an internal sample-rate divider that generates clk_r.
- Sits between the ADC sample interface and the DAC/monitor path. One input sample is accepted and one output is produced per DIV clocks.

Parameters:
- WIDTH, 20: sample and coefficient width, signed two's complement.
- FRAC, 10: fractional bits of samples and coefficients (Q(WIDTH-FRAC).FRAC).
- TAPS, 8: number of filter taps. Must be ≥ 2.
- DIV, 17: clocks per sample period. Must be ≥ TAPS+3; a violation is an elaboration error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- data_i  in  WIDTH  input sample, signed Q format.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index.
- coef_data  in  WIDTH  coefficient value, signed Q format.
- coef_busy  out  1  high while the MAC is running; writes are ignored while high.
- clk_r  out  1  sample-rate square wave.
- data_valid  out  1  one-cycle pulse when data_out updates.
- data_out  out  WIDTH  filtered sample, registered.

Behaviour:
- Reset state:
  - div counter = 0, FSM = IDLE, delay line all 0.
  - coef[0] = 1<<FRAC; coef[1..TAPS-1] = 0. The block is identity after reset.
  - data_out = 0, data_valid = 0, clk_r = 0, coef_busy = 0.
- Divider:
  - cnt counts 0..DIV-1 and wraps.
  - clk_r = 1 while cnt < DIV/2 (integer division), else 0.
  - The sample tick is cnt == 0.
- Capture: on the tick edge, data_i shifts into delay line x[0]; x[k] <= x[k-1]; x[TAPS-1] is discarded.
- FSM, states IDLE, MAC, ROUND, OUT:
  - IDLE -> MAC on tick. acc is cleared and tap index i = 0.
  - MAC: acc += x[i]*coef[i], one product per cycle. Leaves after TAPS cycles (i == TAPS-1) -> ROUND.
  - ROUND: r = (acc + (1<<(FRAC-1))) >>> FRAC (round half up), then saturate to WIDTH -> OUT.
  - OUT: data_out <= r, data_valid = 1 for this cycle only -> IDLE.
- Latency: data_valid pulses TAPS+2 clocks after the capture edge (10 at the defaults). No new tick can arrive before IDLE because of the DIV constraint.
- Widths:
  - Products are 2*WIDTH bits.
  - acc is 2*WIDTH+clog2(TAPS) bits, so no accumulator overflow is possible.
- coef_busy = 1 in MAC and ROUND.
- Coefficient writes:
  - A coef_we while busy is dropped, with no effect and no queuing.
  - When not busy, coef[coef_addr] updates on the clock edge and is used from the next sample.
  - A write in the same cycle as the tick edge is accepted, because busy is still 0 in that cycle.
  - coef_addr ≥ TAPS is ignored.
- Reset asserted mid-MAC: all state, delay line, coefficients and outputs return to the reset values immediately. No partial output is emitted after release.

Optional Feature:
- Macro FILTRO_SAT_EN.
- Defined: ROUND clamps out-of-range results to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
- Undefined: ROUND takes the low WIDTH bits of r (two's-complement wrap), and the saturation logic is not synthesised.

Test Plan:
- Identity after reset:
  - Stimulus: release rst, data_i = 0x00400 (1.0).
  - Expected: data_valid pulses 10 clocks after the capture edge with data_out = 0x00400. clk_r is high for 8 clocks and low for 9.
- Moving average:
  - Stimulus: write all 8 coefs = 0x00080 (0.125), then a step input of 0x00400.
  - Expected: successive outputs 0x00080, 0x00100, … 0x00400, then steady at 0x00400.
- Saturation (FILTRO_SAT_EN defined):
  - Stimulus: coef[0] = 0x7FFFF, data_i = 0x7FFFF.
  - Expected: data_out = 0x7FFFF. With data_i = 0x80001, data_out = 0x80000.
  - With the macro undefined, the same stimulus gives the wrapped low 20 bits.
- Rounding:
  - Stimulus: coef[0] = 0x00200 (0.5).
  - Expected: data_i = 0x00001 gives 0x00001; data_i = 0xFFFFF gives 0x00000.
- Busy write drop:
  - Stimulus: coef_we with coef_addr = 0, coef_data = 0 during MAC (coef_busy = 1).
  - Expected: the next sample of 0x00400 still outputs 0x00400. The same write issued in IDLE makes the following output 0x00000.
- Reset mid-MAC:
  - Stimulus: assert rst for 2 clocks during MAC cycle 3.
  - Expected: data_out = 0, data_valid never pulses for that sample, and coefficients are back to identity afterwards.

Source files
------------

// File: rtl/filtro_fir_seq.sv
// filtro_fir_seq: signed fixed-point FIR filter built around one shared
// multiplier. Each filter output takes one multiply-accumulate per tap.
//
// Operation
//   - An internal divider produces the sample tick and the clk_r square wave.
//   - On each tick the input sample enters the delay line.
//   - The FSM then walks the taps (MAC), rounds and limits the sum (ROUND),
//     and publishes it (OUT).
//
// Build option
//   FILTRO_SAT_EN : when defined, ROUND clamps out-of-range results to the
//                   WIDTH-bit signed limits. When undefined, the result wraps
//                   to its low WIDTH bits and no clamp logic is built.
//
// Coefficient write interface
//   coef_we is a single-cycle write strobe. It has no handshake and no queue.
//   - A write is taken on the clock edge only if coef_busy is low in that cycle.
//   - Otherwise the write is dropped.
//   - Writes to coef_addr >= TAPS are ignored.
//
// Output interface
//   data_valid is a one-cycle pulse. It marks the clock cycle in which
//   data_out first holds a new result. data_out holds its value between
//   pulses.
//
// State visibility
//   state_dbg exposes the FSM state (0 IDLE, 1 MAC, 2 ROUND, 3 OUT).
module filtro_fir_seq #(
  parameter int WIDTH = 20,
  parameter int FRAC  = 10,
  parameter int TAPS  = 8,
  parameter int DIV   = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [WIDTH-1:0]         coef_data,
  output logic                     coef_busy,
  output logic                     clk_r,
  output logic                     data_valid,
  output logic [WIDTH-1:0]         data_out,
  output logic [1:0]               state_dbg
);

  localparam int IDX_W    = $clog2(TAPS);
  localparam int CNT_W    = $clog2(DIV);
  localparam int PROD_W   = 2 * WIDTH;
  localparam int ACC_W    = PROD_W + IDX_W;
  localparam int SH_W     = ACC_W - FRAC;
  localparam int HALF_DIV = DIV / 2;
  localparam bit TAPS_POW2 = ((1 << IDX_W) == TAPS);

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV);
  localparam logic [WIDTH-1:0] COEF_ONE = WIDTH'(1) << FRAC;
  localparam logic [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC - 1);

  // Reject parameter sets for which the schedule cannot work.
  // The MAC, ROUND and OUT phases must all finish before the next tick.
  generate
    if (TAPS < 2) begin : g_bad_taps
      $error("filtro_fir_seq: TAPS must be at least 2");
    end
    if (DIV < TAPS + 3) begin : g_bad_div
      $error("filtro_fir_seq: DIV must be at least TAPS+3");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             tick;

  logic [WIDTH-1:0] x_q    [TAPS];
  logic [WIDTH-1:0] coef_q [TAPS];

  logic [IDX_W-1:0] tap_i;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] r_q;

  logic             acc_clr;
  logic             mac_en;
  logic             round_en;
  logic             out_en;
  logic             addr_ok;
  logic             coef_wr_ok;

  logic [WIDTH-1:0]  x_sel;
  logic [WIDTH-1:0]  c_sel;
  logic [PROD_W-1:0] x_ext;
  logic [PROD_W-1:0] c_ext;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  acc_rnd;
  logic [SH_W-1:0]   r_full;
  logic [WIDTH-1:0]  r_lim;
  logic              unused_rnd_bits;

  assign state_dbg = state;
  assign tick      = (cnt == '0);

  // Sample-rate divider.
  // clk_r is registered, so it trails the counter by one clock.
  // It resets low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      clk_r <= 1'b0;
    end else begin
      cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      clk_r <= (cnt < CNT_HALF);
    end
  end

  // Delay line: on every tick the newest sample enters x[0].
  // The oldest sample drops off the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else if (tick) begin
      x_q[0] <= data_i;
      for (int k = 1; k < TAPS; k++) begin
        x_q[k] <= x_q[k-1];
      end
    end
  end

  // Address range check.
  // It is only needed when TAPS does not fill the address space.
  generate
    if (TAPS_POW2) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_chk
      assign addr_ok = (coef_addr < IDX_W'(TAPS));
    end
  endgenerate

  assign coef_wr_ok = coef_we && !coef_busy && addr_ok;

  // Coefficient bank.
  // It resets to identity: tap 0 = 1.0, all other taps = 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef_q[0] <= COEF_ONE;
      for (int k = 1; k < TAPS; k++) begin
        coef_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (coef_wr_ok && (coef_addr == IDX_W'(k))) begin
          coef_q[k] <= coef_data;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state.
  // A tick only arrives while idle, because DIV >= TAPS+3.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick) state_nxt = S_MAC;
      S_MAC:   if (tap_i == LAST_TAP) state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  // Busy covers MAC and ROUND, so coefficients stay stable while in use.
  always_comb begin
    coef_busy = 1'b0;
    acc_clr   = 1'b0;
    mac_en    = 1'b0;
    round_en  = 1'b0;
    out_en    = 1'b0;
    case (state)
      S_IDLE: begin
        acc_clr = tick;
      end
      S_MAC: begin
        coef_busy = 1'b1;
        mac_en    = 1'b1;
      end
      S_ROUND: begin
        coef_busy = 1'b1;
        round_en  = 1'b1;
      end
      S_OUT: begin
        out_en = 1'b1;
      end
      default: begin
        coef_busy = 1'b0;
      end
    endcase
  end

  // Shared multiplier.
  // Both operands are sign-extended to the full product width.
  // The low 2*WIDTH bits of the product are then exact.
  assign x_sel    = x_q[tap_i];
  assign c_sel    = coef_q[tap_i];
  assign x_ext    = {{WIDTH{x_sel[WIDTH-1]}}, x_sel};
  assign c_ext    = {{WIDTH{c_sel[WIDTH-1]}}, c_sel};
  assign prod     = x_ext * c_ext;
  assign prod_ext = {{IDX_W{prod[PROD_W-1]}}, prod};

  // Round half up.
  // Taking the bits above FRAC is an arithmetic right shift.
  assign acc_rnd = acc + RND_HALF;
  assign r_full  = acc_rnd[ACC_W-1:FRAC];

`ifdef FILTRO_SAT_EN
  // Clamp when the bits above the WIDTH-bit sign bit disagree with it.
  always_comb begin
    r_lim = r_full[WIDTH-1:0];
    if (r_full[SH_W-1:WIDTH-1] != {(SH_W-WIDTH+1){r_full[SH_W-1]}}) begin
      r_lim = r_full[SH_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
  assign unused_rnd_bits = ^acc_rnd[FRAC-1:0];
`else
  // Two's-complement wrap: keep only the low WIDTH bits.
  assign r_lim           = r_full[WIDTH-1:0];
  assign unused_rnd_bits = ^{acc_rnd[FRAC-1:0], r_full[SH_W-1:WIDTH]};
`endif

  // MAC datapath and result register.
  // - The tick clears the accumulator and tap index.
  // - MAC adds one product per cycle.
  // - ROUND latches the rounded, limited result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      tap_i <= '0;
      r_q   <= '0;
    end else begin
      if (acc_clr) begin
        acc   <= '0;
        tap_i <= '0;
      end else if (mac_en) begin
        acc   <= acc + prod_ext;
        tap_i <= (tap_i == LAST_TAP) ? '0 : tap_i + IDX_W'(1);
      end
      if (round_en) begin
        r_q <= r_lim;
      end
    end
  end

  // Output register.
  // data_valid is high only in the cycle after OUT, which is when
  // data_out takes its new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= out_en;
      if (out_en) begin
        data_out <= r_q;
      end
    end
  end

endmodule
